dm_sized: RTL and testbench

Parametrised data-memory controller. It generalises the 1 KiB data memory with halfword-load support into a sized, sign/zero-extending byte-addressed memory. It supports byte, halfword and word loads and stores, configurable depth and configurable wait states. It answers a request/acknowledge handshake, so both the single-cycle and multi-cycle MIPS cores can use it. It sits between the ALU address output and the register-file write-back mux.

---
 rtl/dm_sized.sv | 163 ++++++++++++++++
 tb/tb_dm_sized.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sized.sv
// Sized, byte-addressed data memory with sign/zero-extending loads and a
// req/ack handshake; WAIT_CYCLES adds a fixed number of busy cycles per access.
module dm_sized #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [7:0]          mem [DEPTH];

  logic                we_p0;
  logic [1:0]          size_p0;
  logic                uns_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [31:0]         din_p0;

  logic                accept;
  logic                vld_p0;
  logic                op_we;
  logic [1:0]          op_size;
  logic                op_uns;
  logic [ADDR_W-1:0]   op_addr;
  logic [31:0]         op_din;
  logic                bad;
  logic [3:0]          be;
  logic [ADDR_W-1:0]   baddr [4];
  logic [31:0]         raw;
  logic [31:0]         load_val;
  logic                unused_addr;

  // Misaligned halfword/word or the reserved size code.
  function automatic logic access_err(input logic [1:0] sz, input logic [1:0] a);
    logic e;
    case (sz)
      2'b00:   e = 1'b0;
      2'b01:   e = a[0];
      2'b10:   e = (a != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] r, input logic [1:0] sz,
                                              input logic u);
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{~u & r[7]}}, r[7:0]};
      2'b01:   v = {{16{~u & r[15]}}, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  assign unused_addr = ^addr[31:ADDR_W];
  assign busy        = (state == ST_WAIT);
  assign accept      = req && (state == ST_IDLE);

  // Zero-wait accesses perform on the accepting edge using the live inputs;
  // otherwise the latched request performs when the counter runs out.
  always_comb begin
    vld_p0 = 1'b0;
    if (state == ST_IDLE)
      vld_p0 = accept && (WAIT_CYCLES == 0);
    else
      vld_p0 = (cnt == 4'd0);
  end

  assign op_we   = busy ? we_p0   : we;
  assign op_size = busy ? size_p0 : size;
  assign op_uns  = busy ? uns_p0  : uns;
  assign op_addr = busy ? addr_p0 : addr[ADDR_W-1:0];
  assign op_din  = busy ? din_p0  : din;

  assign bad = access_err(op_size, op_addr[1:0]);
  assign be  = byte_en(op_size);

  always_comb begin
    for (int k = 0; k < 4; k++)
      baddr[k] = op_addr + ADDR_W'(k);
  end

  assign raw      = {mem[baddr[3]], mem[baddr[2]], mem[baddr[1]], mem[baddr[0]]};
  assign load_val = extend_load(raw, op_size, op_uns);

  // ---- request capture (p0) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0   <= we;
      size_p0 <= size;
      uns_p0  <= uns;
      addr_p0 <= addr[ADDR_W-1:0];
      din_p0  <= din;
    end
  end

  // ---- perform: array write ----
  always_ff @(posedge clk) begin
    if (vld_p0 && !rst && op_we && !bad) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[baddr[k]] <= op_din[8*k +: 8];
    end
  end

  // ---- perform: control and result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dout  <= 32'd0;
    end else begin
      ack <= vld_p0;
      case (state)
        ST_IDLE: begin
          if (accept && (WAIT_CYCLES != 0)) begin
            cnt   <= 4'(WAIT_CYCLES - 1);
            state <= ST_WAIT;
          end
        end
        default: begin
          if (cnt == 4'd0)
            state <= ST_IDLE;
          else
            cnt <= cnt - 4'd1;
        end
      endcase
      if (vld_p0) begin
        err  <= bad;
        dout <= (bad || op_we) ? 32'd0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_dm_sized.sv
// Scoreboard bench for dm_sized: one zero-wait and one three-wait instance,
// directed cases plus random traffic against a byte-array reference model.
module tb_dm_sized;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v  [2];
  logic        req_v  [2];
  logic        we_v   [2];
  logic        uns_v  [2];
  logic [1:0]  size_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] din_v  [2];
  logic [31:0] dout_v [2];
  logic        ack_v  [2];
  logic        err_v  [2];
  logic        busy_v [2];

  dm_sized #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .size(size_v[0]),
    .uns(uns_v[0]), .addr(addr_v[0]), .din(din_v[0]), .dout(dout_v[0]),
    .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]));

  dm_sized #(.ADDR_W(10), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .size(size_v[1]),
    .uns(uns_v[1]), .addr(addr_v[1]), .din(din_v[1]), .dout(dout_v[1]),
    .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]));

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [7:0]  mmem [2][1024];
  logic [31:0] last_dout [2];
  logic        last_err  [2];

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic void q_push(input int d, input logic [32:0] v);
    if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [32:0] q_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Reference: {err, dout}; stores update the byte array, loads assemble bytes.
  function automatic logic [32:0] model(input int d, input bit w, input logic [1:0] sz,
                                        input bit u, input logic [31:0] a,
                                        input logic [31:0] di);
    int          nb;
    logic [31:0] val;
    logic [31:0] ba;
    nb = 1 << sz;
    if (sz == 2'b11 || (a % nb) != 0) return {1'b1, 32'd0};
    val = 32'd0;
    for (int i = 0; i < nb; i++) begin
      ba = a + i;
      if (w) mmem[d][ba[9:0]] = di[8*i +: 8];
      else   val = val | (32'(mmem[d][ba[9:0]]) << (8 * i));
    end
    if (w) return {1'b0, 32'd0};
    if (!u && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
    return {1'b0, val};
  endfunction

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_v[d] !== 1'b0) begin
      @(posedge clk); #1;
      n++;
      if (n > 64) begin
        n_tests++; n_fail++;
        $display("FAIL busy_timeout dut%0d: busy=%b, expected 0", d, busy_v[d]);
        break;
      end
    end
  endtask

  task automatic issue(input int d, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] di,
                       input bit use_c, input logic [32:0] c);
    logic [32:0] m;
    wait_idle(d);
    we_v[d] = w; size_v[d] = sz; uns_v[d] = u; addr_v[d] = a; din_v[d] = di;
    req_v[d] = 1'b1;
    m = model(d, w, sz, u, a, di);
    q_push(d, use_c ? c : m);
    @(posedge clk); #1;
    req_v[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (ack_v[d] === 1'b1) begin
          if (q_size(d) == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_ack dut%0d: dout=%h err=%b, expected no ack",
                     d, dout_v[d], err_v[d]);
          end else begin
            logic [32:0] e;
            e = q_pop(d);
            check("ack_dout", d, dout_v[d], e[31:0]);
            check("ack_err", d, 32'(err_v[d]), 32'(e[32]));
            check("ack_busy", d, 32'(busy_v[d]), 32'd0);
            last_dout[d] = e[31:0];
            last_err[d]  = e[32];
          end
        end else begin
          check("hold_dout", d, dout_v[d], last_dout[d]);
          check("hold_err", d, 32'(err_v[d]), 32'(last_err[d]));
          check("ack_lvl", d, 32'(ack_v[d]), 32'd0);
          if (d == 0) check("busy0_low", d, 32'(busy_v[0]), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; req_v[d] = 1'b0; we_v[d] = 1'b0; uns_v[d] = 1'b0;
      size_v[d] = 2'b00; addr_v[d] = 32'd0; din_v[d] = 32'd0;
      last_dout[d] = 32'd0; last_err[d] = 1'b0;
      for (int i = 0; i < 1024; i++) mmem[d][i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_dout", d, dout_v[d], 32'd0);
      check("rst_ack", d, 32'(ack_v[d]), 32'd0);
      check("rst_err", d, 32'(err_v[d]), 32'd0);
      check("rst_busy", d, 32'(busy_v[d]), 32'd0);
    end
    mon_en = 1'b1;

    // Deterministic zero fill of both arrays.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        issue(d, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'd0, 1'b1, 33'd0);

    // Zero-wait directed: back-to-back sw/lw, extensions, partial stores, errors.
    issue(0, 1, 2'b10, 0, 32'h010, 32'h876543A1, 1, 33'd0);
    issue(0, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h876543A1});
    issue(0, 0, 2'b00, 0, 32'h010, 32'd0, 1, {1'b0, 32'hFFFFFFA1});
    issue(0, 0, 2'b00, 1, 32'h010, 32'd0, 1, {1'b0, 32'h000000A1});
    issue(0, 0, 2'b00, 0, 32'h011, 32'd0, 1, {1'b0, 32'h00000043});
    issue(0, 0, 2'b01, 0, 32'h012, 32'd0, 1, {1'b0, 32'hFFFF8765});
    issue(0, 0, 2'b01, 1, 32'h012, 32'd0, 1, {1'b0, 32'h00008765});
    issue(0, 1, 2'b00, 0, 32'h011, 32'h000000CC, 1, 33'd0);
    issue(0, 1, 2'b01, 0, 32'h012, 32'h00001234, 1, 33'd0);
    issue(0, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h1234CCA1});
    issue(0, 0, 2'b10, 0, 32'h410, 32'd0, 1, {1'b0, 32'h1234CCA1});
    issue(0, 0, 2'b10, 0, 32'h012, 32'd0, 1, {1'b1, 32'd0});
    issue(0, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h1234CCA1});
    issue(0, 1, 2'b01, 0, 32'h013, 32'hFFFFFFFF, 1, {1'b1, 32'd0});
    issue(0, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h1234CCA1});
    issue(0, 1, 2'b11, 0, 32'h010, 32'hFFFFFFFF, 1, {1'b1, 32'd0});
    issue(0, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h1234CCA1});

    // Three-wait directed: busy window, ignored req, acceptance in the ack cycle.
    issue(1, 1, 2'b10, 0, 32'h010, 32'h1234CCA1, 1, 33'd0);
    wait_idle(1);
    we_v[1] = 1'b0; size_v[1] = 2'b10; uns_v[1] = 1'b0; addr_v[1] = 32'h010;
    req_v[1] = 1'b1;
    q_push(1, {1'b0, 32'h1234CCA1});
    q_push(1, {1'b0, 32'h1234CCA1});
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check("w3_busy", 1, 32'(busy_v[1]), (e < 4) ? 32'd1 : 32'd0);
      check("w3_ack", 1, 32'(ack_v[1]), (e < 4) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    check("w3_reaccept", 1, 32'(busy_v[1]), 32'd1);

    // Reset two edges after acceptance aborts a pending store.
    wait_idle(1);
    we_v[1] = 1'b1; size_v[1] = 2'b10; addr_v[1] = 32'h010; din_v[1] = 32'hDEADBEEF;
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    last_dout[1] = 32'd0; last_err[1] = 1'b0;
    check("abort_busy", 1, 32'(busy_v[1]), 32'd0);
    check("abort_ack", 1, 32'(ack_v[1]), 32'd0);
    check("abort_dout", 1, dout_v[1], 32'd0);
    check("abort_err", 1, 32'(err_v[1]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    issue(1, 0, 2'b10, 0, 32'h010, 32'd0, 1, {1'b0, 32'h1234CCA1});

    // Random traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < ((d == 0) ? 400 : 100); n++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 3));
        a  = $urandom;
        if ($urandom_range(0, 4) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
        issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              0, 33'd0);
      end
    end

    begin
      int n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("pending_acks", 0, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
